ymn_sr_serializer: RTL and testbench
====================================

Name: ymn_sr_serializer

Overview:
- Parallel-in, serial-out transmitter for the two-phase (c1/c2) shift-register fabric.
- Generates its own non-overlapping c1/c2 enable pulses from MCLK and accepts words over a valid/ready handshake.
- Drives each bit on sout so that a downstream c1/c2 serial-in chain (ymn_sr_bit / ymn_sr_bit_array) captures it on c1.
- Used for test feeds and serial links between Nuked-SMS blocks.

Parameters:
- DATA_WIDTH, 8, word width in bits (2..32).
- PHASE_DIV, 2, MCLK cycles per half bit-period (1..64); bit period is 2*PHASE_DIV MCLK cycles.
- MSB_FIRST, 1, 1 = shift out MSB first, 0 = LSB first.

Ports:
- MCLK  input  1  system clock; all state updates on its rising edge.
- MRESET_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid.
- load_data  input  DATA_WIDTH  word to transmit.
- load_ready  output  1  block can accept a word.
- c1  output  1  phase-1 enable pulse, one MCLK wide.
- c2  output  1  phase-2 enable pulse, one MCLK wide.
- sout  output  1  serial data.
- busy  output  1  word accepted and not yet fully sent.
- done  output  1  one-MCLK pulse after the last bit's period ends.

Behaviour:
- Reset (MRESET_n=0, async): ph=0, c1=0, c2=0, sout=0, busy=0, done=0, load_ready=0, shift register and bit count 0, state IDLE. load_ready rises on the first MCLK edge after release.
- Phase generator (free-running, independent of the data state):
  - ph counts 0..2*PHASE_DIV-1 and wraps.
  - c1, c2 and sout are flops.
  - Each edge: c1 <= (ph==2*PHASE_DIV-1); c2 <= (ph==PHASE_DIV-1).
  - c1 and c2 are never high in the same cycle.
  - With PHASE_DIV=2, the first c2 is high after edge 2 and the first c1 after edge 4, counting from reset release.
- "c2 event" = an MCLK edge at which the c2 flop is 1. sout changes only at c2 events, so it is stable through every c1 cycle.
- States:
  - IDLE: load_ready=1, busy=0, sout=0. On load_valid&&load_ready, capture load_data into sreg, clear bit count, go to ARM. load_ready and busy update on that same edge.
  - ARM: waits for the next c2 event. At that event, sout <= first bit (sreg[DATA_WIDTH-1] if MSB_FIRST, else sreg[0]), shift sreg, cnt <= 1, go to SHIFT.
  - SHIFT: at each c2 event:
    - if cnt < DATA_WIDTH: sout <= next bit, shift, cnt++.
    - if cnt == DATA_WIDTH: sout <= 0, done=1 for exactly that one cycle, state IDLE, busy=0, load_ready=1.
- Each bit is held for exactly 2*PHASE_DIV MCLK cycles and spans exactly one c1 pulse.
- Latency: a word accepted while ARM waits at most 2*PHASE_DIV edges for its first bit.
- load_valid is ignored while load_ready=0. load_data is sampled only at the accept edge.
- An accept edge that coincides with a c2 event still enters ARM. The first bit appears at the following c2 event, never at the coincident one.
- Reset mid-word aborts the word immediately, with no done pulse.
- Bit count width is clog2(DATA_WIDTH+1).

Optional Feature:
- Macro: YMN_SR_SERIALIZER_STREAM_EN.
- Defined:
  - load_ready is also 1 in SHIFT when cnt==DATA_WIDTH.
  - An accept in that state, or an accept coinciding with the final c2 event, skips IDLE/ARM.
  - At the final c2 event the new word's first bit is driven directly, done still pulses, and there is no idle bit period.
- Undefined: load_ready is 1 only in IDLE, and at least one ARM wait separates words.

Test Plan:
- Reset release, no load, PHASE_DIV=2 -> c2 high in cycles 2,6,10…, c1 high in cycles 4,8,12…; never both high; sout=0; load_ready=1 from cycle 1.
- Load 0xA5, MSB_FIRST=1, DATA_WIDTH=8 -> sout = 1,0,1,0,0,1,0,1, each held 4 MCLK and centred on one c1; done pulses once, 4 cycles after the last bit starts; busy covers accept→done.
- Same word with MSB_FIRST=0 feeding an 8-stage c1/c2 serial-in chain clocked by c1/c2 -> after 8 c1 pulses the chain holds 0xA5 (MSB_FIRST=1 case) / bit-reversed 0xA5 (MSB_FIRST=0 case).
- load_valid held high with 0x3C then 0xFF while busy -> 0xFF is not accepted until load_ready=1; both words are sent intact, in order.
- MRESET_n pulsed low during bit 4 of 0x5A -> outputs go to reset values asynchronously, no done pulse; the next word 0x81 is sent correctly.
- YMN_SR_SERIALIZER_STREAM_EN defined, 0x0F then 0xF0 back-to-back -> 16 contiguous bit periods with no idle period, and two done pulses.

Source files
------------

// File: rtl/ymn_sr_serializer.sv
// Parallel-in, serial-out transmitter driving a c1/c2 serial-in chain; bits change on c2 and are captured on c1.
// Optional YMN_SR_SERIALIZER_STREAM_EN: a word queued during the last bit follows it with no idle bit period.
module ymn_sr_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int PHASE_DIV  = 2,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  MCLK,
   input  logic                  MRESET_n,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  c1,
   output logic                  c2,
   output logic                  sout,
   output logic                  busy,
   output logic                  done
);
   localparam int PH_W  = $clog2(2 * PHASE_DIV);
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * PHASE_DIV - 1);
   localparam logic [PH_W-1:0]  PH_MID   = PH_W'(PHASE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
`ifdef YMN_SR_SERIALIZER_STREAM_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
`endif

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_SHIFT} state_t;

   state_t                state_q;
   logic [PH_W-1:0]       ph_q, ph_d;
   logic                  c1_q, c2_q, sout_q, busy_q, done_q, load_ready_q;
   logic [DATA_WIDTH-1:0] sreg_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  accept;
`ifdef YMN_SR_SERIALIZER_STREAM_EN
   logic                  pend_q;
`endif

   function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
   endfunction

   assign accept     = load_valid && load_ready_q;
   assign load_ready = load_ready_q;
   assign c1         = c1_q;
   assign c2         = c2_q;
   assign sout       = sout_q;
   assign busy       = busy_q;
   assign done       = done_q;

   always_comb begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
   end

   // Free-running phase generator; c2 leads c1 by half a bit period.
   always_ff @(posedge MCLK or negedge MRESET_n) begin
      if (!MRESET_n) begin
         ph_q <= '0;
         c1_q <= 1'b0;
         c2_q <= 1'b0;
      end else begin
         ph_q <= ph_d;
         c1_q <= (ph_q == PH_LAST);
         c2_q <= (ph_q == PH_MID);
      end
   end

   always_ff @(posedge MCLK or negedge MRESET_n) begin
      if (!MRESET_n) begin
         state_q      <= S_IDLE;
         sreg_q       <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b0;
`ifdef YMN_SR_SERIALIZER_STREAM_EN
         pend_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               load_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               sout_q       <= 1'b0;
               if (accept) begin
                  sreg_q       <= load_data;
                  cnt_q        <= '0;
                  state_q      <= S_ARM;
                  load_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
               end
            end
            S_ARM: begin
               if (c2_q) begin
                  sout_q  <= head_bit(sreg_q);
                  sreg_q  <= shift_out(sreg_q);
                  cnt_q   <= CNT_W'(1);
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (c2_q) begin
                  if (cnt_q != CNT_FULL) begin
                     sout_q <= head_bit(sreg_q);
                     sreg_q <= shift_out(sreg_q);
                     cnt_q  <= cnt_q + CNT_W'(1);
`ifdef YMN_SR_SERIALIZER_STREAM_EN
                     if (cnt_q == CNT_LAST) load_ready_q <= 1'b1;
`endif
                  end else begin
                     done_q <= 1'b1;
`ifdef YMN_SR_SERIALIZER_STREAM_EN
                     // A word offered on this very edge takes priority; otherwise use the queued one.
                     if (accept) begin
                        sout_q       <= head_bit(load_data);
                        sreg_q       <= shift_out(load_data);
                        cnt_q        <= CNT_W'(1);
                        load_ready_q <= 1'b0;
                     end else if (pend_q) begin
                        sout_q <= head_bit(sreg_q);
                        sreg_q <= shift_out(sreg_q);
                        cnt_q  <= CNT_W'(1);
                        pend_q <= 1'b0;
                     end else begin
                        sout_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                     end
`else
                     sout_q       <= 1'b0;
                     busy_q       <= 1'b0;
                     load_ready_q <= 1'b1;
                     state_q      <= S_IDLE;
`endif
                  end
               end
`ifdef YMN_SR_SERIALIZER_STREAM_EN
               else if (accept) begin
                  sreg_q       <= load_data;
                  pend_q       <= 1'b1;
                  load_ready_q <= 1'b0;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ymn_sr_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) fed identical words, checked cycle by cycle.
module tb_ymn_sr_serializer;
   localparam int MAXN = 127;

   logic       MCLK      = 1'b0;
   logic       MRESET_n  = 1'b1;
   logic       load_valid = 1'b0;
   logic [7:0] load_data  = 8'h00;

   logic rdy_m, c1_m, c2_m, so_m, busy_m, done_m;
   logic rdy_l, c1_l, c2_l, so_l, busy_l, done_l;

   int vectors = 0;
   int errors  = 0;
   int edges   = 0;

   logic [7:0] chain_m, chain_l;

   // Expected values after edge n, and input drive applied after edge n.
   logic       em  [0:MAXN];
   logic       el  [0:MAXN];
   logic       eb  [0:MAXN];
   logic       ed  [0:MAXN];
   logic       elr [0:MAXN];
   logic       lv  [0:MAXN];
   logic [7:0] ld  [0:MAXN];

   ymn_sr_serializer #(.DATA_WIDTH(8), .PHASE_DIV(2), .MSB_FIRST(1'b1)) u_msb (
      .MCLK(MCLK), .MRESET_n(MRESET_n), .load_valid(load_valid), .load_data(load_data),
      .load_ready(rdy_m), .c1(c1_m), .c2(c2_m), .sout(so_m), .busy(busy_m), .done(done_m)
   );

   ymn_sr_serializer #(.DATA_WIDTH(8), .PHASE_DIV(2), .MSB_FIRST(1'b0)) u_lsb (
      .MCLK(MCLK), .MRESET_n(MRESET_n), .load_valid(load_valid), .load_data(load_data),
      .load_ready(rdy_l), .c1(c1_l), .c2(c2_l), .sout(so_l), .busy(busy_l), .done(done_l)
   );

   always #5 MCLK = ~MCLK;

   always @(posedge MCLK or negedge MRESET_n) begin
      if (!MRESET_n) edges <= 0;
      else           edges <= edges + 1;
   end

   // Downstream serial-in chains capturing sout on each c1 pulse.
   always @(posedge MCLK) begin
      if (c1_m) chain_m <= {chain_m[6:0], so_m};
      if (c1_l) chain_l <= {chain_l[6:0], so_l};
   end

   task automatic clear_sched;
      for (int n = 0; n <= MAXN; n++) begin
         em[n] = 1'b0; el[n] = 1'b0; eb[n] = 1'b0; ed[n] = 1'b0;
         elr[n] = (n != 0);
         lv[n] = 1'b0; ld[n] = 8'h00;
      end
   endtask

   // Word accepted at edge a, first bit driven at c2 event edge f.
   task automatic sched_word(input logic [7:0] w, input int a, input int f);
      for (int n = a; n < f + 32; n++) begin
         eb[n]  = 1'b1;
         elr[n] = 1'b0;
      end
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 4; j++) begin
            em[f + 4*k + j] = w[7-k];
            el[f + 4*k + j] = w[k];
         end
      ed[f + 32] = 1'b1;
`ifdef YMN_SR_SERIALIZER_STREAM_EN
      for (int n = f + 28; n < f + 32; n++) elr[n] = 1'b1;
`endif
   endtask

   task automatic hold_valid(input int from, input int to, input logic [7:0] w);
      for (int n = from; n <= to; n++) begin
         lv[n] = 1'b1;
         ld[n] = w;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [11:0] got;
      got = {rdy_m, c1_m, c2_m, so_m, busy_m, done_m, rdy_l, c1_l, c2_l, so_l, busy_l, done_l};
      vectors++;
      if (got !== 12'b0) begin
         errors++;
         $display("FAIL %s reset outputs {rdy,c1,c2,sout,busy,done}x2 got %b expected %b", name, got, 12'b0);
      end
   endtask

   task automatic do_reset(input string name);
      @(negedge MCLK);
      load_valid = 1'b0;
      load_data  = 8'h00;
      MRESET_n   = 1'b0;
      #1 check_reset_outputs({name, "_async"});
      @(negedge MCLK);
      check_reset_outputs({name, "_held"});
      MRESET_n = 1'b1;
   endtask

   task automatic run(input string name, input int last);
      int n;
      logic [7:0] got_v, exp_v;
      logic [3:0] got_p, exp_p;
      n = edges;
      load_valid = lv[n];
      load_data  = ld[n];
      while (n < last) begin
         @(negedge MCLK);
         n = edges;
         got_p = {c1_m, c2_m, c1_l, c2_l};
         exp_p = {(n != 0) && (n % 4 == 0), (n % 4 == 2), (n != 0) && (n % 4 == 0), (n % 4 == 2)};
         vectors++;
         if (got_p !== exp_p) begin
            errors++;
            $display("FAIL %s_phase cycle %0d {c1_m,c2_m,c1_l,c2_l} got %b expected %b", name, n, got_p, exp_p);
         end
         got_v = {so_m, so_l, busy_m, busy_l, done_m, done_l, rdy_m, rdy_l};
         exp_v = {em[n], el[n], eb[n], eb[n], ed[n], ed[n], elr[n], elr[n]};
         vectors++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d {sout_m,sout_l,busy_m,busy_l,done_m,done_l,rdy_m,rdy_l} got %b expected %b",
                     name, n, got_v, exp_v);
         end
         load_valid = lv[n];
         load_data  = ld[n];
      end
   endtask

   task automatic check_chains(input string name, input logic [7:0] exp_m, input logic [7:0] exp_l);
      vectors++;
      if ({chain_m, chain_l} !== {exp_m, exp_l}) begin
         errors++;
         $display("FAIL %s_chain got msb=%h lsb=%h expected msb=%h lsb=%h", name, chain_m, chain_l, exp_m, exp_l);
      end
   endtask

   task automatic test_reset;
      do_reset("reset");
      clear_sched();
      run("idle", 13);
   endtask

   task automatic test_word_a5;
      do_reset("a5_rst");
      clear_sched();
      sched_word(8'hA5, 2, 3);
      hold_valid(1, 1, 8'hA5);
      run("a5", 35);
      check_chains("a5", 8'hA5, 8'hA5);
      run("a5_tail", 38);
   endtask

   // Accept lands on a c2 event edge; first bit must wait for the next one.
   task automatic test_coincident_accept;
      do_reset("coinc_rst");
      clear_sched();
      sched_word(8'h1D, 3, 7);
      hold_valid(2, 2, 8'h1D);
      run("coinc", 39);
      check_chains("coinc", 8'h1D, 8'hB8);
      run("coinc_tail", 42);
   endtask

   task automatic test_back_to_back(input string name, input logic [7:0] w1, input logic [7:0] w2);
      int a2, f2;
`ifdef YMN_SR_SERIALIZER_STREAM_EN
      a2 = 32; f2 = 35;
`else
      a2 = 36; f2 = 39;
`endif
      do_reset({name, "_rst"});
      clear_sched();
      sched_word(w1, 2, 3);
      sched_word(w2, a2, f2);
      hold_valid(1, 1, w1);
      hold_valid(2, a2 - 1, w2);
      run(name, f2 + 35);
   endtask

   task automatic test_reset_mid_word;
      do_reset("mid_rst0");
      clear_sched();
      sched_word(8'h5A, 2, 3);
      hold_valid(1, 1, 8'h5A);
      run("mid_5a", 16);
      do_reset("mid_abort");
      clear_sched();
      sched_word(8'h81, 2, 3);
      hold_valid(1, 1, 8'h81);
      run("mid_81", 35);
      check_chains("mid_81", 8'h81, 8'h81);
      run("mid_81_tail", 40);
   endtask

   initial begin
      test_reset();
      test_word_a5();
      test_coincident_accept();
      test_back_to_back("b2b_3c_ff", 8'h3C, 8'hFF);
      test_back_to_back("b2b_0f_f0", 8'h0F, 8'hF0);
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
